// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   state_t  : FSM state encoding (also exported on the debug state port)
//   iclass_t : instruction class produced by the decoder
//   OP_*/FN_*: supported opcode and R-type function codes
//   *_SEL/ALU_*/EXT_*/NPC_*: datapath select encodings
package mc_control_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_MDU    = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_ALU,   // register-writing ops that go EXEC -> WB (incl. ori/lui/mfhi/mflo)
      C_LW,
      C_SW,
      C_BEQ,
      C_JR,
      C_JAL,
      C_MULT,
      C_ILL
   } iclass_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;

   localparam int REGDST_RT  = 0;
   localparam int REGDST_RD  = 1;
   localparam int REGDST_RA  = 2;

   localparam int ALUSRC_RD2 = 0;
   localparam int ALUSRC_EXT = 1;

   localparam int TOREG_ALU  = 0;
   localparam int TOREG_MDR  = 1;
   localparam int TOREG_EXT  = 2;
   localparam int TOREG_PC4  = 3;
   localparam int TOREG_HI   = 4;
   localparam int TOREG_LO   = 5;

   localparam int NPC_SEQ    = 0;
   localparam int NPC_BEQ    = 1;
   localparam int NPC_JAL    = 2;
   localparam int NPC_JR     = 3;

   localparam int ALU_NOP    = 0;
   localparam int ALU_OR     = 1;
   localparam int ALU_ADD    = 2;
   localparam int ALU_SUB    = 3;
   localparam int ALU_XOR    = 5;

   localparam int EXT_ZERO   = 0;
   localparam int EXT_SIGN   = 1;
   localparam int EXT_LUI    = 2;

endpackage

// File: rtl/mc_control_if.sv
// Control <-> datapath/memory bundle for mc_control.
//   master : the control unit (reads Op/Func/Zero/mem_ready, drives strobes/selects)
//   slave  : the datapath + memory side
interface mc_control_if #(
   parameter int SEL_W   = 3,
   parameter int ALUOP_W = 4
);
   logic [5:0]         Op;
   logic [5:0]         Func;
   logic               Zero;
   logic               mem_ready;

   logic               mem_req;
   logic               MemWrite;
   logic               IRWrite;
   logic               PCWrite;
   logic               RegWrite;
   logic               HiLoWrite;
   logic [SEL_W-1:0]   RegDstSel;
   logic [SEL_W-1:0]   ALUSrcSel;
   logic [SEL_W-1:0]   toRegSel;
   logic [SEL_W-1:0]   NPCOp;
   logic [ALUOP_W-1:0] ALUOp;
   logic [SEL_W-1:0]   EXTOp;
   logic               illegal;
   logic [2:0]         state;

   modport master (
      input  Op, Func, Zero, mem_ready,
      output mem_req, MemWrite, IRWrite, PCWrite, RegWrite, HiLoWrite,
             RegDstSel, ALUSrcSel, toRegSel, NPCOp, ALUOp, EXTOp, illegal, state
   );

   modport slave (
      output Op, Func, Zero, mem_ready,
      input  mem_req, MemWrite, IRWrite, PCWrite, RegWrite, HiLoWrite,
             RegDstSel, ALUSrcSel, toRegSel, NPCOp, ALUOp, EXTOp, illegal, state
   );
endinterface

// File: rtl/mc_control_decode.sv
// Combinational instruction decoder for mc_control.
//   op, func : IR[31:26], IR[5:0]
//   iclass   : sequencing class (C_ILL for anything unsupported)
//   regdst, alusrc, toreg, aluop, extop : datapath selects for the instruction
module mc_control_decode import mc_control_pkg::*; #(
   parameter int SEL_W   = 3,
   parameter int ALUOP_W = 4
) (
   input  logic [5:0]         op,
   input  logic [5:0]         func,
   output iclass_t            iclass,
   output logic [SEL_W-1:0]   regdst,
   output logic [SEL_W-1:0]   alusrc,
   output logic [SEL_W-1:0]   toreg,
   output logic [ALUOP_W-1:0] aluop,
   output logic [SEL_W-1:0]   extop
);

   always_comb begin
      iclass = C_ILL;
      regdst = '0;
      alusrc = '0;
      toreg  = '0;
      aluop  = '0;
      extop  = '0;
      case (op)
         OP_RTYPE: begin
            case (func)
               FN_ADDU: begin iclass = C_ALU;  regdst = SEL_W'(REGDST_RD); aluop = ALUOP_W'(ALU_ADD); end
               FN_SUBU: begin iclass = C_ALU;  regdst = SEL_W'(REGDST_RD); aluop = ALUOP_W'(ALU_SUB); end
               FN_OR:   begin iclass = C_ALU;  regdst = SEL_W'(REGDST_RD); aluop = ALUOP_W'(ALU_OR);  end
               FN_XOR:  begin iclass = C_ALU;  regdst = SEL_W'(REGDST_RD); aluop = ALUOP_W'(ALU_XOR); end
               FN_MFHI: begin iclass = C_ALU;  regdst = SEL_W'(REGDST_RD); toreg = SEL_W'(TOREG_HI); end
               FN_MFLO: begin iclass = C_ALU;  regdst = SEL_W'(REGDST_RD); toreg = SEL_W'(TOREG_LO); end
               FN_JR:   iclass = C_JR;
               FN_MULT: iclass = C_MULT;
               default: iclass = C_ILL;
            endcase
         end
         OP_ORI: begin
            iclass = C_ALU;
            alusrc = SEL_W'(ALUSRC_EXT);
            aluop  = ALUOP_W'(ALU_OR);
            extop  = SEL_W'(EXT_ZERO);
         end
         OP_LUI: begin
            iclass = C_ALU;
            toreg  = SEL_W'(TOREG_EXT);
            extop  = SEL_W'(EXT_LUI);
         end
         OP_LW: begin
            iclass = C_LW;
            alusrc = SEL_W'(ALUSRC_EXT);
            toreg  = SEL_W'(TOREG_MDR);
            aluop  = ALUOP_W'(ALU_ADD);
            extop  = SEL_W'(EXT_SIGN);
         end
         OP_SW: begin
            iclass = C_SW;
            alusrc = SEL_W'(ALUSRC_EXT);
            aluop  = ALUOP_W'(ALU_ADD);
            extop  = SEL_W'(EXT_SIGN);
         end
         OP_BEQ: begin
            iclass = C_BEQ;
            aluop  = ALUOP_W'(ALU_SUB);
            extop  = SEL_W'(EXT_SIGN);  // branch offset
         end
         OP_JAL: begin
            iclass = C_JAL;
            regdst = SEL_W'(REGDST_RA);
            toreg  = SEL_W'(TOREG_PC4);
         end
         default: iclass = C_ILL;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mc_control_if master -- Op/Func/Zero/mem_ready in; memory
//                handshake, write strobes, datapath selects, illegal flag and
//                debug state out.
// Each instruction is decoded once in S_DECODE; its class and selects are
// latched there so later states do not depend on the decoder.
module mc_control import mc_control_pkg::*; #(
   parameter int SEL_W      = 3,
   parameter int ALUOP_W    = 4,
   parameter int MDU_CYCLES = 5,
   parameter int CNT_W      = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   mc_control_if.master bus
);

   iclass_t            dec_class;
   logic [SEL_W-1:0]   dec_regdst, dec_alusrc, dec_toreg, dec_extop;
   logic [ALUOP_W-1:0] dec_aluop;

   mc_control_decode #(.SEL_W(SEL_W), .ALUOP_W(ALUOP_W)) u_decode (
      .op     (bus.Op),
      .func   (bus.Func),
      .iclass (dec_class),
      .regdst (dec_regdst),
      .alusrc (dec_alusrc),
      .toreg  (dec_toreg),
      .aluop  (dec_aluop),
      .extop  (dec_extop)
   );

   state_t             st;
   iclass_t            cls_q;
   logic [CNT_W-1:0]   cnt;
   logic [SEL_W-1:0]   regdst_q, alusrc_q, toreg_q, extop_q;
   logic [ALUOP_W-1:0] aluop_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= S_FETCH;
         cls_q    <= C_ILL;
         cnt      <= '0;
         regdst_q <= '0;
         alusrc_q <= '0;
         toreg_q  <= '0;
         aluop_q  <= '0;
         extop_q  <= '0;
      end else begin
         case (st)
            S_FETCH: if (bus.mem_ready) st <= S_DECODE;
            S_DECODE: begin
               cls_q    <= dec_class;
               regdst_q <= dec_regdst;
               alusrc_q <= dec_alusrc;
               toreg_q  <= dec_toreg;
               aluop_q  <= dec_aluop;
               extop_q  <= dec_extop;
               case (dec_class)
                  C_ILL:   st <= S_FETCH;
                  C_JAL:   st <= S_WB;
                  default: st <= S_EXEC;
               endcase
            end
            S_EXEC: begin
               case (cls_q)
                  C_ALU:       st <= S_WB;
                  C_LW, C_SW:  st <= S_MEM;
                  C_MULT: begin
                     cnt <= CNT_W'(MDU_CYCLES - 1);
                     st  <= S_MDU;
                  end
                  default:     st <= S_FETCH;  // beq, jr
               endcase
            end
            S_MEM: if (bus.mem_ready) st <= (cls_q == C_LW) ? S_WB : S_FETCH;
            S_MDU: begin
               if (cnt == '0) st  <= S_FETCH;
               else           cnt <= cnt - 1'b1;
            end
            S_WB:    st <= S_FETCH;
            default: st <= S_FETCH;
         endcase
      end
   end

   logic               mem_req, memwrite, irwrite, pcwrite, regwrite, hilowrite, illegal;
   logic [SEL_W-1:0]   npcop, regdst, alusrc, toreg, extop;
   logic [ALUOP_W-1:0] aluop;

   // Strobes come from the registered state; rst_n gates them so that
   // nothing (mem_req included) is asserted while reset is held.
   always_comb begin
      mem_req   = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      pcwrite   = 1'b0;
      regwrite  = 1'b0;
      hilowrite = 1'b0;
      illegal   = 1'b0;
      npcop     = SEL_W'(NPC_SEQ);
      if (rst_n) begin
         case (st)
            S_FETCH: begin
               mem_req = 1'b1;
               irwrite = bus.mem_ready;
            end
            S_DECODE: begin
               if (dec_class == C_ILL) begin
                  illegal = 1'b1;
                  pcwrite = 1'b1;
               end
            end
            S_EXEC: begin
               if (cls_q == C_BEQ) begin
                  pcwrite = 1'b1;
                  npcop   = bus.Zero ? SEL_W'(NPC_BEQ) : SEL_W'(NPC_SEQ);
               end else if (cls_q == C_JR) begin
                  pcwrite = 1'b1;
                  npcop   = SEL_W'(NPC_JR);
               end
            end
            S_MEM: begin
               mem_req  = 1'b1;
               memwrite = (cls_q == C_SW);
               pcwrite  = (cls_q == C_SW) && bus.mem_ready;
            end
            S_MDU: begin
               hilowrite = (cnt == '0);
               pcwrite   = (cnt == '0);
            end
            S_WB: begin
               regwrite = 1'b1;
               pcwrite  = 1'b1;
               npcop    = (cls_q == C_JAL) ? SEL_W'(NPC_JAL) : SEL_W'(NPC_SEQ);
            end
            default: ;
         endcase
      end
   end

   // In S_DECODE the latched copies are not yet loaded, so the decoder
   // drives the selects directly for that one cycle.
   always_comb begin
      regdst = '0;
      alusrc = '0;
      toreg  = '0;
      aluop  = '0;
      extop  = '0;
      if (st == S_DECODE) begin
         regdst = dec_regdst;
         alusrc = dec_alusrc;
         toreg  = dec_toreg;
         aluop  = dec_aluop;
         extop  = dec_extop;
      end else if (st != S_FETCH) begin
         regdst = regdst_q;
         alusrc = alusrc_q;
         toreg  = toreg_q;
         aluop  = aluop_q;
         extop  = extop_q;
      end
   end

   assign bus.mem_req   = mem_req;
   assign bus.MemWrite  = memwrite;
   assign bus.IRWrite   = irwrite;
   assign bus.PCWrite   = pcwrite;
   assign bus.RegWrite  = regwrite;
   assign bus.HiLoWrite = hilowrite;
   assign bus.illegal   = illegal;
   assign bus.NPCOp     = npcop;
   assign bus.RegDstSel = regdst;
   assign bus.ALUSrcSel = alusrc;
   assign bus.toRegSel  = toreg;
   assign bus.ALUOp     = aluop;
   assign bus.EXTOp     = extop;
   assign bus.state     = st;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios followed by random
// instruction streams with random memory wait states, compared cycle by
// cycle against a phase-list model of each instruction.
module tb_mc_control;

   localparam int MDU_C = 5;

   // Phase numbers are the architectural state numbers.
   localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PX = 5;

   typedef enum {K_ALU, K_LW, K_SW, K_BEQ, K_JR, K_JAL, K_MULT, K_ILL} kind_t;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] func;
      kind_t      k;
      int         rd, as, tr, ao, eo;
   } instr_t;

   localparam int NTAB = 17;
   instr_t tab [NTAB];

   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   mc_control_if #(.SEL_W(3), .ALUOP_W(4)) bus ();

   mc_control #(.SEL_W(3), .ALUOP_W(4), .MDU_CYCLES(MDU_C), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int lat_of(kind_t k);
      case (k)
         K_ILL:                return 2;
         K_BEQ, K_JR, K_JAL:   return 3;
         K_ALU, K_SW:          return 4;
         K_LW:                 return 5;
         K_MULT:               return 3 + MDU_C;
         default:              return 0;
      endcase
   endfunction

   // Run one instruction. sf / sm = cycles mem_ready is held low in the
   // fetch and data-memory phases; zero = value of the ALU Zero flag.
   task automatic run_instr(input int idx, input bit zero, input int sf, input int sm);
      instr_t e;
      int     ph[$];
      int     p, cyc, left, pc_at, cur, last, done, exp_pc, sel_e, st_e, lat_e;
      bit     rdy;
      e  = tab[idx];
      ph = {PF, PD};
      case (e.k)
         K_ILL: ;
         K_JAL: ph.push_back(PW);
         default: begin
            ph.push_back(PE);
            case (e.k)
               K_ALU:  ph.push_back(PW);
               K_LW:   begin ph.push_back(PM); ph.push_back(PW); end
               K_SW:   ph.push_back(PM);
               K_MULT: for (int i = 0; i < MDU_C; i++) ph.push_back(PX);
               default: ;
            endcase
         end
      endcase
      bus.Op   = e.op;
      bus.Func = (e.op == 6'h00) ? e.func : 6'($urandom);
      sel_e    = (e.rd << 13) | (e.as << 10) | (e.tr << 7) | (e.ao << 3) | e.eo;
      p = 0; cyc = 0; left = sf; pc_at = -1;
      while (p < ph.size()) begin
         cur = ph[p];
         if (cur == PF || cur == PM) rdy = (left == 0);
         else                        rdy = 1'($urandom_range(0, 1));
         bus.mem_ready = rdy;
         bus.Zero      = (e.k == K_BEQ) ? zero : 1'($urandom_range(0, 1));
         @(negedge clk);
         last   = (p == ph.size() - 1);
         done   = (cur == PF || cur == PM) ? int'(rdy) : 1;
         exp_pc = last && done;
         st_e   = (cur << 7)
                | (((cur == PF) || (cur == PM)) << 6)
                | (((cur == PM) && (e.k == K_SW)) << 5)
                | (((cur == PF) && rdy) << 4)
                | (exp_pc << 3)
                | ((cur == PW) << 2)
                | (((cur == PX) && last) << 1)
                | ((cur == PD) && (e.k == K_ILL));
         chk($sformatf("%s c%0d state/strobes", e.name, cyc),
             {bus.state, bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite,
              bus.RegWrite, bus.HiLoWrite, bus.illegal}, st_e);
         if (exp_pc)
            chk($sformatf("%s c%0d NPCOp", e.name, cyc), bus.NPCOp,
                (e.k == K_JAL) ? 2 : (e.k == K_JR) ? 3 : (e.k == K_BEQ) ? int'(zero) : 0);
         if (cur != PF)
            chk($sformatf("%s c%0d selects", e.name, cyc),
                {bus.RegDstSel, bus.ALUSrcSel, bus.toRegSel, bus.ALUOp, bus.EXTOp}, sel_e);
         if (bus.PCWrite && pc_at < 0) pc_at = cyc;
         @(posedge clk); #1;
         cyc++;
         if ((cur == PF || cur == PM) && !rdy) left--;
         else begin
            p++;
            if (p < ph.size() && ph[p] == PM) left = sm;
         end
      end
      lat_e = lat_of(e.k) - 1 + sf + ((e.k == K_LW || e.k == K_SW) ? sm : 0);
      chk($sformatf("%s PCWrite cycle", e.name), pc_at, lat_e);
   endtask

   // Abort a store while it waits in MEM; the write must vanish at once.
   task automatic reset_in_mem();
      bus.Op = 6'h2b; bus.Func = 6'($urandom); bus.mem_ready = 1'b1; bus.Zero = 1'b0;
      repeat (3) begin @(negedge clk); @(posedge clk); #1; end
      bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("sw MEM before reset", {bus.state, bus.mem_req, bus.MemWrite}, {3'd3, 1'b1, 1'b1});
      #1 rst_n = 1'b0;
      #1;
      chk("async reset strobes", {bus.mem_req, bus.MemWrite, bus.PCWrite, bus.RegWrite}, 4'b0000);
      chk("async reset state", bus.state, 0);
      @(posedge clk); #1;
      chk("reset held PCWrite/state", {bus.PCWrite, bus.state}, 4'b0000);
      rst_n = 1'b1;
   endtask

   initial begin
      tab[0]  = '{"addu",  6'h00, 6'h21, K_ALU,  1, 0, 0, 2, 0};
      tab[1]  = '{"subu",  6'h00, 6'h23, K_ALU,  1, 0, 0, 3, 0};
      tab[2]  = '{"or",    6'h00, 6'h25, K_ALU,  1, 0, 0, 1, 0};
      tab[3]  = '{"xor",   6'h00, 6'h26, K_ALU,  1, 0, 0, 5, 0};
      tab[4]  = '{"ori",   6'h0d, 6'h00, K_ALU,  0, 1, 0, 1, 0};
      tab[5]  = '{"lui",   6'h0f, 6'h00, K_ALU,  0, 0, 2, 0, 2};
      tab[6]  = '{"mfhi",  6'h00, 6'h10, K_ALU,  1, 0, 4, 0, 0};
      tab[7]  = '{"mflo",  6'h00, 6'h12, K_ALU,  1, 0, 5, 0, 0};
      tab[8]  = '{"lw",    6'h23, 6'h00, K_LW,   0, 1, 1, 2, 1};
      tab[9]  = '{"sw",    6'h2b, 6'h00, K_SW,   0, 1, 0, 2, 1};
      tab[10] = '{"beq",   6'h04, 6'h00, K_BEQ,  0, 0, 0, 3, 1};
      tab[11] = '{"jr",    6'h00, 6'h08, K_JR,   0, 0, 0, 0, 0};
      tab[12] = '{"jal",   6'h03, 6'h00, K_JAL,  2, 0, 3, 0, 0};
      tab[13] = '{"mult",  6'h00, 6'h18, K_MULT, 0, 0, 0, 0, 0};
      tab[14] = '{"ill3f", 6'h3f, 6'h00, K_ILL,  0, 0, 0, 0, 0};
      tab[15] = '{"illfn", 6'h00, 6'h01, K_ILL,  0, 0, 0, 0, 0};
      tab[16] = '{"ill02", 6'h02, 6'h00, K_ILL,  0, 0, 0, 0, 0};

      rst_n = 1'b0;
      bus.Op = '0; bus.Func = '0; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset state/strobes",
          {bus.state, bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite,
           bus.RegWrite, bus.HiLoWrite, bus.illegal}, 0);
      chk("reset selects",
          {bus.RegDstSel, bus.ALUSrcSel, bus.toRegSel, bus.ALUOp, bus.EXTOp, bus.NPCOp}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_instr(0, 1'b0, 0, 0);    // addu, zero wait
      run_instr(8, 1'b0, 0, 3);    // lw, 3 wait cycles in MEM
      run_instr(10, 1'b1, 0, 0);   // beq taken
      run_instr(10, 1'b0, 0, 0);   // beq not taken
      run_instr(13, 1'b0, 0, 0);   // mult
      run_instr(7, 1'b0, 0, 0);    // mflo
      run_instr(14, 1'b0, 0, 0);   // illegal opcode
      run_instr(12, 1'b0, 2, 0);   // jal with fetch stall
      run_instr(9, 1'b0, 1, 2);    // sw with both stalls
      reset_in_mem();
      run_instr(0, 1'b0, 0, 0);    // recovery after reset

      for (int n = 0; n < 400; n++) begin
         int sf, sm;
         sf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         sm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         run_instr(int'($urandom_range(0, NTAB - 1)), 1'($urandom_range(0, 1)), sf, sm);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
